// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bundle for seq_bit_serializer: valid/ready word handshake plus serial outputs.
interface seq_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, x, x_valid, frame_start, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, x, x_valid, frame_start, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial source: sends WIDTH-bit words one bit per clock on x with optional idle gap.
// Define SER_PARITY_EN to append an even-parity bit after the data bits of every frame.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP       = 0,
  parameter int unsigned MSB_FIRST = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_bit_serializer_if.slave ser
);

`ifdef SER_PARITY_EN
  localparam int unsigned Flen = WIDTH + 1;
`else
  localparam int unsigned Flen = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Flen - 1);
  localparam logic [3:0] GapLast = 4'(GAP == 0 ? 0 : GAP - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       gap_q;
  logic             x_q;
  logic             x_valid_q;
  logic             frame_start_q;
`ifdef SER_PARITY_EN
  localparam logic [CntW-1:0] CntDataLast = CntW'(WIDTH - 1);
  logic             parity_q;
`endif

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_shift;
  logic [WIDTH-1:0] next_shift;

  assign last_bit     = (state_q == StShift) && (cnt_q == CntLast);
  // Back-to-back chaining is only possible when no gap follows the frame.
  assign ser.in_ready = (state_q == StIdle) || (last_bit && (GAP == 0));
  assign accept       = ser.in_valid && ser.in_ready;

  // shift_q holds the bits still to be sent; the bit on x has already been shifted out.
  assign first_bit  = (MSB_FIRST != 0) ? ser.in_data[WIDTH-1] : ser.in_data[0];
  assign load_shift = (MSB_FIRST != 0) ? (ser.in_data << 1) : (ser.in_data >> 1);
  assign next_bit   = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
  assign next_shift = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      frame_start_q <= 1'b0;
      if (accept) begin
        state_q       <= StShift;
        shift_q       <= load_shift;
        cnt_q         <= '0;
        x_q           <= first_bit;
        x_valid_q     <= 1'b1;
        frame_start_q <= 1'b1;
`ifdef SER_PARITY_EN
        parity_q      <= ^ser.in_data;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
          end
          StShift: begin
            if (cnt_q == CntLast) begin
              cnt_q     <= '0;
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
              if (GAP != 0) begin
                state_q <= StGap;
                gap_q   <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              shift_q <= next_shift;
`ifdef SER_PARITY_EN
              if (cnt_q == CntDataLast) x_q <= parity_q;
              else
`endif
              x_q <= next_bit;
            end
          end
          StGap: begin
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            if (gap_q == GapLast) begin
              state_q <= StIdle;
              gap_q   <= '0;
            end else begin
              gap_q <= gap_q + 4'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ser.x           = x_q;
  assign ser.x_valid     = x_valid_q;
  assign ser.frame_start = frame_start_q;
  assign ser.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: one GAP=0/MSB-first instance, one GAP=2/LSB-first one.
module tb_seq_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) b0 ();
  seq_bit_serializer_if #(.WIDTH(W)) b1 ();

  seq_bit_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ser   (b0)
  );

  seq_bit_serializer #(.WIDTH(W), .GAP(2), .MSB_FIRST(0)) u_dut_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .ser   (b1)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Entry = {ready expected on this bit, frame_start, x}.
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  int run0 = 0, maxrun0 = 0;
  int gap1 = 0;
  bit seen1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_frame(input int sel, input logic [W-1:0] w);
    logic [2:0] e;
    logic       b;
    bit         msb  = (sel == 0);
    bit         gap0 = (sel == 0);
    for (int i = 0; i < FLEN; i++) begin
      if (i == W) b = ^w;
      else b = msb ? w[W-1-i] : w[i];
      e = {gap0 && (i == FLEN - 1), i == 0, b};
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endfunction

  // Holds in_valid high until accepted; caller drops in_valid.
  task automatic send(input int sel, input logic [W-1:0] w);
    logic rdy;
    rdy = 1'b0;
    if (sel == 0) begin
      b0.in_data = w; b0.in_valid = 1'b1;
    end else begin
      b1.in_data = w; b1.in_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = (sel == 0) ? b0.in_ready : b1.in_ready;
      if (rdy) break;
    end
    chk("accept_rdy", {31'd0, rdy}, 1);
    push_frame(sel, w);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (b0.x_valid) begin
      run0++;
      if (run0 > maxrun0) maxrun0 = run0;
      chk("busy0", {31'd0, b0.busy}, 1);
      if (q0.size() == 0) chk("x0_extra", q0.size(), 1);
      else begin
        e = q0.pop_front();
        chk("x0_bit", {31'd0, b0.x}, {31'd0, e[0]});
        chk("x0_fs", {31'd0, b0.frame_start}, {31'd0, e[1]});
        chk("x0_rdy", {31'd0, b0.in_ready}, {31'd0, e[2]});
      end
    end else begin
      run0 = 0;
      chk("x0_idle", {31'd0, b0.x}, 0);
      chk("x0_fsidle", {31'd0, b0.frame_start}, 0);
      chk("x0_rdyidle", {31'd0, b0.in_ready}, {31'd0, !b0.busy});
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (b1.busy && !b1.x_valid) gap1++;
    if (b1.x_valid) begin
      if (b1.frame_start) begin
        if (seen1) chk("gap_len", gap1, 2);
        seen1 = 1'b1;
        gap1 = 0;
      end
      if (q1.size() == 0) chk("x1_extra", q1.size(), 1);
      else begin
        e = q1.pop_front();
        chk("x1_bit", {31'd0, b1.x}, {31'd0, e[0]});
        chk("x1_fs", {31'd0, b1.frame_start}, {31'd0, e[1]});
        chk("x1_rdy", {31'd0, b1.in_ready}, {31'd0, e[2]});
      end
    end else begin
      chk("x1_idle", {31'd0, b1.x}, 0);
      chk("x1_rdyidle", {31'd0, b1.in_ready}, {31'd0, !b1.busy});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.in_data = '0; b0.in_valid = 1'b0;
    b1.in_data = '0; b1.in_valid = 1'b0;
    #12;
    chk("rst_x", {31'd0, b0.x}, 0);
    chk("rst_xv", {31'd0, b0.x_valid}, 0);
    chk("rst_fs", {31'd0, b0.frame_start}, 0);
    chk("rst_busy", {31'd0, b0.busy}, 0);
    chk("rst_rdy", {31'd0, b0.in_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(0, 8'hCC);
    b0.in_valid = 1'b0;
    drain();

    send(0, 8'hF0);
    send(0, 8'h0F);
    b0.in_valid = 1'b0;
    drain();
    chk("b2b_run", maxrun0, 2 * FLEN);

    send(1, 8'h5A);
    send(1, 8'h96);
    b1.in_valid = 1'b0;
    drain();

    send(1, 8'h01);
    b1.in_valid = 1'b0;
    drain();

    // Abort 0xA5 during its fourth bit; nothing of it may follow the reset.
    send(0, 8'hA5);
    b0.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_x", {31'd0, b0.x}, 0);
    chk("abort_xv", {31'd0, b0.x_valid}, 0);
    chk("abort_busy", {31'd0, b0.busy}, 0);
    chk("abort_rdy", {31'd0, b0.in_ready}, 1);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 8'h3C);
    b0.in_valid = 1'b0;
    drain();

    send(0, 8'hC8);
    b0.in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
